load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits downstream of the control decoder and ALU in the RV32I core.
- Consumes the decoder's Load/Store strobes, fun3, the ALU effective address and rs2 data.
- Issues exactly one registered request per load/store to a variable-latency data memory, with byte-lane masking and store-data replication.
- Returns sign- or zero-extended load data to writeback and stalls the PC/register file until the access completes.

Parameters:
- TIMEOUT, 255: maximum cycles spent in REQ waiting for mem_ready before the access is aborted with fault.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- load  in  1  decoder Load strobe
- store  in  1  decoder Store strobe
- fun3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu, 110 treated as w
- addr  in  32  effective byte address from ALU
- store_data  in  32  rs2 value
- load_data  out  32  extended load result, registered
- stall  out  1  hold PC and regfile write (combinational)
- fault  out  1  one-cycle pulse: misaligned, unsupported fun3, load&store both high, or timeout
- mem_req  out  1  request valid, registered
- mem_we  out  1  1 = write
- mem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- mem_wdata  out  32  lane-replicated store data
- mem_wmask  out  4  byte-enable, 0000 on reads
- mem_ready  in  1  memory completion, sampled only while mem_req=1
- mem_rdata  in  32  read word, valid with mem_ready

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - State to IDLE; timeout counter to 0.
  - Registered outputs: mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, mem_wmask=0, load_data=0, fault=0.
  - Reset mid-access abandons the pending request; mem_req is low the cycle after reset.
- States: IDLE, REQ, DONE.
- IDLE:
  - On (load^store) with legal fun3 and aligned addr: capture mem_we=store, mem_addr, mem_wdata, mem_wmask, addr[1:0] and fun3; go to REQ.
  - Legal fun3 for loads: 000, 001, 010, 100, 101, 110. For stores: 000, 001, 010.
  - Alignment: h/hu/sh require addr[0]=0; w/sw/fun3 110 require addr[1:0]=00.
  - Illegal fun3, misalignment, or load&store both high: no request, fault=1 next cycle, stay in IDLE, load_data unchanged.
- REQ:
  - mem_req=1 and all request fields held stable.
  - mem_ready=1: capture the extracted load result into load_data (loads only), go to DONE.
  - Counter reaches TIMEOUT-1 without mem_ready: go to DONE with fault=1 and load_data=0.
- DONE:
  - One cycle; mem_req=0; stall=0 so the core retires the instruction at the end of this cycle.
  - Next state is IDLE, which sees the next instruction; no double issue.
- stall:
  - Equals (IDLE & (load|store) & access legal) | REQ.
  - stall=0 in DONE and for any faulting access.
- Latency: minimum 3 cycles per access (IDLE detect, REQ with mem_ready=1, DONE); each extra wait cycle adds one.
- Store lanes, with o = addr[1:0]:
  - sb: wmask = 0001<<o, wdata = {4{sd[7:0]}}.
  - sh: wmask = 0011<<o, wdata = {2{sd[15:0]}}.
  - sw: wmask = 1111, wdata = sd.
- Load extraction, with s = mem_rdata >> (8*o):
  - lb: sign-extend s[7:0]; lbu: zero-extend s[7:0].
  - lh: sign-extend s[15:0]; lhu: zero-extend s[15:0].
  - lw/110: mem_rdata.
- load_data holds its value until the next load completion or reset. Stores and faults (except timeout) leave it unchanged.
- mem_ready while mem_req=0 is ignored.

Test Plan:
- sw addr=0x100, store_data=0xDEADBEEF, mem_ready 1 cycle after REQ entry → mem_req high 2 cycles, mem_addr=0x100, wmask=1111, wdata=0xDEADBEEF; stall high 3 cycles; fault=0.
- lb addr=0x203, mem_rdata=0x80AABBCC, ready immediate → load_data=0xFFFFFF80 in DONE. Same access as lbu → 0x00000080.
- sh addr=0x102, store_data=0x00001234 → wmask=1100, wdata=0x12341234. lh addr=0x101 → no mem_req, fault pulse, stall=0.
- lw with mem_ready delayed 5 cycles → stall high 7 cycles, load_data=mem_rdata; with TIMEOUT=4 and no ready → fault=1, load_data=0, return to IDLE.
- rst asserted while in REQ → next cycle mem_req=0, state IDLE; a later mem_ready pulse has no effect; next lw proceeds normally.
- Back-to-back sw then lw on consecutive instructions → two distinct requests, no duplicate issue, one DONE each.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: one registered request per access to a variable-latency data memory
module load_store_unit #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        load,
   input  logic        store,
   input  logic [2:0]  fun3,
   input  logic [31:0] addr,
   input  logic [31:0] store_data,
   output logic [31:0] load_data,
   output logic        stall,
   output logic        fault,
   output logic        mem_req,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wmask,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   state_t        state;
   state_t        state_nx;
   logic [CW-1:0] cnt;
   logic [1:0]    off_q;
   logic [2:0]    fun3_q;

   logic          fun3_ok;
   logic          aligned;
   logic          access_ok;
   logic          issue;
   logic          bad;
   logic          complete;
   logic          expire;
   logic [3:0]    lane_mask;
   logic [31:0]   lane_data;
   logic [31:0]   shifted;
   logic [31:0]   ext_data;

   // Loads accept every size/sign code except x11; stores only the three signed sizes.
   assign fun3_ok   = store ? (~fun3[2] & (fun3[1:0] != 2'b11)) : (fun3[1:0] != 2'b11);
   assign access_ok = (load ^ store) & fun3_ok & aligned;

   always_comb begin
      aligned = 1'b0;
      case (fun3[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~addr[0];
         2'b10:   aligned = (addr[1:0] == 2'b00);
         default: aligned = 1'b0;
      endcase
   end

   always_comb begin
      lane_mask = 4'b1111;
      lane_data = store_data;
      case (fun3[1:0])
         2'b00: begin
            lane_mask = 4'b0001 << addr[1:0];
            lane_data = {4{store_data[7:0]}};
         end
         2'b01: begin
            lane_mask = 4'b0011 << addr[1:0];
            lane_data = {2{store_data[15:0]}};
         end
         default: ;
      endcase
   end

   // Word loads always have a zero offset, so the shifted word is the read word itself.
   assign shifted = mem_rdata >> {off_q, 3'b000};

   always_comb begin
      ext_data = shifted;
      case (fun3_q)
         3'b000:  ext_data = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ext_data = {24'h000000, shifted[7:0]};
         3'b001:  ext_data = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ext_data = {16'h0000, shifted[15:0]};
         default: ext_data = shifted;
      endcase
   end

   always_comb begin
      state_nx = state;
      stall    = 1'b0;
      issue    = 1'b0;
      bad      = 1'b0;
      complete = 1'b0;
      expire   = 1'b0;
      case (state)
         IDLE: begin
            if (access_ok) begin
               issue    = 1'b1;
               stall    = 1'b1;
               state_nx = REQ;
            end else if (load | store) begin
               bad = 1'b1;
            end
         end
         REQ: begin
            stall = 1'b1;
            if (mem_ready) begin
               complete = 1'b1;
               state_nx = DONE;
            end else if (cnt == CNT_LAST) begin
               expire   = 1'b1;
               state_nx = DONE;
            end
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         off_q     <= 2'b00;
         fun3_q    <= 3'b000;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= 32'h0;
         mem_wdata <= 32'h0;
         mem_wmask <= 4'b0000;
         load_data <= 32'h0;
         fault     <= 1'b0;
      end else begin
         state <= state_nx;
         fault <= bad | expire;
         if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= store;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= store ? lane_data : 32'h0;
            mem_wmask <= store ? lane_mask : 4'b0000;
            off_q     <= addr[1:0];
            fun3_q    <= fun3;
            cnt       <= '0;
         end else if (complete) begin
            mem_req <= 1'b0;
            if (!mem_we) begin
               load_data <= ext_data;
            end
         end else if (expire) begin
            mem_req   <= 1'b0;
            load_data <= 32'h0;
         end else if (state == REQ) begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit
module tb_load_store_unit;

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wmask;
   } req_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        load, store;
   logic [2:0]  fun3;
   logic [31:0] addr, store_data;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic [31:0] load_data, mem_addr, mem_wdata;
   logic        stall, fault, mem_req, mem_we;
   logic [3:0]  mem_wmask;

   logic        mirror_ready;
   logic        t_mem_ready;
   logic [31:0] t_load_data, t_mem_addr, t_mem_wdata;
   logic        t_stall, t_fault, t_mem_req, t_mem_we;
   logic [3:0]  t_mem_wmask;

   int          errors = 0;
   int          checks = 0;
   req_t        req_q[$];
   logic [31:0] ld_q[$];
   req_t        cur;
   int          req_cycles = 0;
   int          req_rises = 0;
   int          n_push = 0;
   logic        req_d = 1'b0;
   logic [31:0] last_ld = 32'h0;

   assign t_mem_ready = mirror_ready ? mem_ready : 1'b0;

   always #5 clk = ~clk;

   load_store_unit u_dut (
      .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3), .addr(addr),
      .store_data(store_data), .load_data(load_data), .stall(stall), .fault(fault),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
   );

   load_store_unit #(.TIMEOUT(4)) u_dut_to (
      .clk(clk), .rst(rst), .load(load), .store(store), .fun3(fun3), .addr(addr),
      .store_data(store_data), .load_data(t_load_data), .stall(t_stall), .fault(t_fault),
      .mem_req(t_mem_req), .mem_we(t_mem_we), .mem_addr(t_mem_addr), .mem_wdata(t_mem_wdata),
      .mem_wmask(t_mem_wmask), .mem_ready(t_mem_ready), .mem_rdata(mem_rdata)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic int nbytes(input logic [2:0] f3);
      if (f3[1:0] == 2'b00) return 1;
      if (f3[1:0] == 2'b01) return 2;
      return 4;
   endfunction

   function automatic bit legal(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] a);
      int b;
      if (ld == st) return 0;
      if (st && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2)) return 0;
      if (ld && !(f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5 || f3 == 3'd6)) return 0;
      b = nbytes(f3);
      return (int'(a[1:0]) % b) == 0;
   endfunction

   function automatic logic [3:0] model_mask(input logic [2:0] f3, input logic [1:0] o);
      logic [3:0] m;
      for (int i = 0; i < 4; i++) m[i] = (i >= int'(o)) && (i < int'(o) + nbytes(f3));
      return m;
   endfunction

   function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] sd);
      logic [31:0] w;
      for (int i = 0; i < 4; i++) w[8*i +: 8] = sd[8*(i % nbytes(f3)) +: 8];
      return w;
   endfunction

   function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [1:0] o, input logic [31:0] rd);
      logic [31:0] r;
      int b;
      b = nbytes(f3);
      r = 32'h0;
      for (int k = 0; k < b; k++) r[8*k +: 8] = rd[8*(int'(o) + k) +: 8];
      if (!f3[2] && b < 4 && r[8*b-1]) begin
         for (int k = 8 * b; k < 32; k++) r[k] = 1'b1;
      end
      return r;
   endfunction

   // Every new request must match the oldest queued expectation and stay stable while held.
   always @(negedge clk) begin
      if (!rst && mem_req) begin
         if (!req_d) begin
            req_rises++;
            checks++;
            assert (req_q.size() != 0) else begin
               errors++;
               $error("FAIL spurious_req observed=%h expected=none", mem_addr);
            end
            if (req_q.size() != 0) cur = req_q.pop_front();
         end
         chk("req_we", {31'h0, mem_we}, {31'h0, cur.we});
         chk("req_addr", mem_addr, cur.addr);
         chk("req_wmask", {28'h0, mem_wmask}, {28'h0, cur.wmask});
         if (cur.we) chk("req_wdata", mem_wdata, cur.wdata);
         req_cycles++;
      end
      req_d = mem_req;
   end

   task automatic access(input logic ld, input logic st, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd, input int d);
      req_t        r;
      logic [31:0] exp_ld;
      int          sc, rc0;
      load = ld; store = st; fun3 = f3; addr = a; store_data = sd; mem_ready = 1'b0;
      if (!legal(ld, st, f3, a)) begin
         @(negedge clk);
         chk("bad_stall", {31'h0, stall}, 32'h0);
         @(posedge clk); #1;
         load = 1'b0; store = 1'b0;
         @(negedge clk);
         chk("bad_fault", {31'h0, fault}, 32'h1);
         chk("bad_no_req", {31'h0, mem_req}, 32'h0);
         chk("bad_ld_hold", load_data, last_ld);
         @(negedge clk);
         chk("fault_pulse", {31'h0, fault}, 32'h0);
         @(posedge clk); #1;
         return;
      end
      r.we    = st;
      r.addr  = {a[31:2], 2'b00};
      r.wmask = st ? model_mask(f3, a[1:0]) : 4'b0000;
      r.wdata = model_wdata(f3, sd);
      req_q.push_back(r);
      n_push++;
      exp_ld = ld ? model_load(f3, a[1:0], rd) : last_ld;
      ld_q.push_back(exp_ld);
      rc0 = req_cycles;
      @(negedge clk);
      sc = stall;
      @(posedge clk); #1;
      for (int n = 0; n <= d; n++) begin
         mem_ready = (n == d);
         mem_rdata = (n == d) ? rd : ~rd;
         @(negedge clk);
         sc += int'(stall);
         @(posedge clk); #1;
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h0;
      @(negedge clk);
      chk("done_stall", {31'h0, stall}, 32'h0);
      chk("done_req", {31'h0, mem_req}, 32'h0);
      chk("done_fault", {31'h0, fault}, 32'h0);
      chk("load_data", load_data, ld_q.pop_front());
      chk("stall_cycles", sc, d + 2);
      chk("req_cycles", req_cycles - rc0, d + 1);
      last_ld = exp_ld;
      @(posedge clk); #1;
      load = 1'b0; store = 1'b0;
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      load = 1'b0; store = 1'b0; mem_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      last_ld = 32'h0;
   endtask

   initial begin
      int sc;
      rst = 1'b1; load = 1'b0; store = 1'b0; fun3 = 3'b000; addr = 32'h0;
      store_data = 32'h0; mem_ready = 1'b0; mem_rdata = 32'h0; mirror_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
      chk("rst_mem_we", {31'h0, mem_we}, 32'h0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wmask", {28'h0, mem_wmask}, 32'h0);
      chk("rst_load_data", load_data, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_stall", {31'h0, stall}, 32'h0);
      @(posedge clk); #1;
      rst = 1'b0;

      access(1'b0, 1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 1);
      access(1'b1, 1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 0);
      access(1'b1, 1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80AA_BBCC, 0);
      access(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_1234, 32'h0, 0);
      access(1'b1, 1'b0, 3'b001, 32'h0000_0101, 32'h0, 32'h0, 0);
      access(1'b1, 1'b0, 3'b010, 32'h0000_0104, 32'h0, 32'hCAFE_F00D, 5);
      access(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h0000_00A5, 32'h0, 2);
      access(1'b1, 1'b0, 3'b001, 32'h0000_0200, 32'h0, 32'h80AA_BBCC, 1);
      access(1'b1, 1'b0, 3'b101, 32'h0000_0202, 32'h0, 32'h80AA_BBCC, 0);
      access(1'b1, 1'b0, 3'b110, 32'h0000_0208, 32'h0, 32'h1357_9BDF, 0);
      access(1'b0, 1'b1, 3'b100, 32'h0000_0100, 32'h1111_2222, 32'h0, 0);
      access(1'b1, 1'b0, 3'b011, 32'h0000_0100, 32'h0, 32'h0, 0);
      access(1'b1, 1'b1, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0);
      access(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h0, 0);

      // Back-to-back store then load with no idle gap between them.
      access(1'b0, 1'b1, 3'b010, 32'h0000_0500, 32'hA1B2_C3D4, 32'h0, 0);
      access(1'b1, 1'b0, 3'b010, 32'h0000_0500, 32'h0, 32'hA1B2_C3D4, 0);

      // Reset while a load sits in REQ.
      load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h0000_0300;
      req_q.push_back('{we: 1'b0, addr: 32'h0000_0300, wdata: 32'h0, wmask: 4'b0000});
      n_push++;
      @(posedge clk); #1;
      @(negedge clk);
      chk("pre_rst_req", {31'h0, mem_req}, 32'h1);
      @(posedge clk); #1;
      pulse_reset();
      @(negedge clk);
      chk("post_rst_req", {31'h0, mem_req}, 32'h0);
      chk("post_rst_stall", {31'h0, stall}, 32'h0);
      chk("post_rst_ld", load_data, 32'h0);
      mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clk); #1;
      mem_ready = 1'b0;
      @(negedge clk);
      chk("stray_ready_req", {31'h0, mem_req}, 32'h0);
      chk("stray_ready_ld", load_data, 32'h0);
      chk("stray_ready_fault", {31'h0, fault}, 32'h0);
      @(posedge clk); #1;
      access(1'b1, 1'b0, 3'b010, 32'h0000_0304, 32'h0, 32'h2468_ACE0, 0);

      // Timeout on the TIMEOUT=4 instance after it has a nonzero load result.
      pulse_reset();
      mirror_ready = 1'b1;
      access(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0, 32'h1234_5678, 0);
      chk("to_pre_ld", t_load_data, 32'h1234_5678);
      mirror_ready = 1'b0;
      load = 1'b1; store = 1'b0; fun3 = 3'b010; addr = 32'h0000_0404;
      req_q.push_back('{we: 1'b0, addr: 32'h0000_0404, wdata: 32'h0, wmask: 4'b0000});
      n_push++;
      @(negedge clk);
      sc = t_stall;
      @(posedge clk); #1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (t_fault) break;
         sc += int'(t_stall);
         @(posedge clk); #1;
      end
      chk("to_fault", {31'h0, t_fault}, 32'h1);
      chk("to_load_data", t_load_data, 32'h0);
      chk("to_mem_req", {31'h0, t_mem_req}, 32'h0);
      chk("to_stall_done", {31'h0, t_stall}, 32'h0);
      chk("to_stall_cycles", sc, 5);
      @(posedge clk); #1;
      load = 1'b0;
      @(negedge clk);
      chk("to_fault_pulse", {31'h0, t_fault}, 32'h0);
      chk("to_idle_req", {31'h0, t_mem_req}, 32'h0);
      chk("main_still_req", {31'h0, mem_req}, 32'h1);
      @(posedge clk); #1;
      pulse_reset();
      @(negedge clk);

      chk("req_q_empty", req_q.size(), 0);
      chk("ld_q_empty", ld_q.size(), 0);
      chk("req_count", req_rises, n_push);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
